// File: rtl/alu_arbiter_if.sv
// rtl/alu_arbiter_if.sv - request/response channels for two ALU clients plus the shared ALU port
interface alu_arbiter_if #(
   parameter int WIDTH = 32,
   parameter int SEL_W = 4
);
   logic             req0_valid;
   logic             req0_ready;
   logic [WIDTH-1:0] req0_a;
   logic [WIDTH-1:0] req0_b;
   logic [SEL_W-1:0] req0_sel;
   logic             req1_valid;
   logic             req1_ready;
   logic [WIDTH-1:0] req1_a;
   logic [WIDTH-1:0] req1_b;
   logic [SEL_W-1:0] req1_sel;

   logic             rsp0_valid;
   logic             rsp0_ready;
   logic [WIDTH-1:0] rsp0_data;
   logic             rsp0_carry;
   logic             rsp1_valid;
   logic             rsp1_ready;
   logic [WIDTH-1:0] rsp1_data;
   logic             rsp1_carry;

   logic [WIDTH-1:0] alu_a;
   logic [WIDTH-1:0] alu_b;
   logic [SEL_W-1:0] alu_sel;
   logic [WIDTH-1:0] alu_out;
   logic             alu_carry;

   logic             busy;
   logic             grant_id;

   modport master (
      output req0_valid, req0_a, req0_b, req0_sel,
      output req1_valid, req1_a, req1_b, req1_sel,
      output rsp0_ready, rsp1_ready, alu_out, alu_carry,
      input  req0_ready, req1_ready,
      input  rsp0_valid, rsp0_data, rsp0_carry,
      input  rsp1_valid, rsp1_data, rsp1_carry,
      input  alu_a, alu_b, alu_sel, busy, grant_id
   );

   modport slave (
      input  req0_valid, req0_a, req0_b, req0_sel,
      input  req1_valid, req1_a, req1_b, req1_sel,
      input  rsp0_ready, rsp1_ready, alu_out, alu_carry,
      output req0_ready, req1_ready,
      output rsp0_valid, rsp0_data, rsp0_carry,
      output rsp1_valid, rsp1_data, rsp1_carry,
      output alu_a, alu_b, alu_sel, busy, grant_id
   );
endinterface

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - round-robin sharing of one combinational ALU between two requesters
// One op in flight: accept, one EXEC cycle on registered operands, then hold the result until taken.
module alu_arbiter #(
   parameter int WIDTH = 32,
   parameter int SEL_W = 4
) (
   input logic          clk,
   input logic          rst,
   alu_arbiter_if.slave bus
);
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic             last_grant;
   logic             grant_q;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic [SEL_W-1:0] sel_q;
   logic [WIDTH-1:0] data_q;
   logic             carry_q;
   logic             rdy0;
   logic             rdy1;
   logic             acc0;
   logic             acc1;
   logic             rsp_done;

   always_comb begin
      state_nxt = state;
      rdy0      = 1'b0;
      rdy1      = 1'b0;
      acc0      = 1'b0;
      acc1      = 1'b0;
      rsp_done  = 1'b0;
      case (state)
         IDLE: begin
            // Under contention the side that did not win last time goes first.
            rdy0 = !rst && (!bus.req1_valid || (bus.req0_valid && last_grant));
            rdy1 = !rst && bus.req1_valid && (!bus.req0_valid || !last_grant);
            acc0 = rdy0 && bus.req0_valid;
            acc1 = rdy1;
            if (acc0 || acc1) begin
               state_nxt = EXEC;
            end
         end
         EXEC: begin
            state_nxt = RESP;
         end
         RESP: begin
            rsp_done = grant_q ? bus.rsp1_ready : bus.rsp0_ready;
            if (rsp_done) begin
               state_nxt = IDLE;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         last_grant <= 1'b1;
         grant_q    <= 1'b0;
         a_q        <= '0;
         b_q        <= '0;
         sel_q      <= '0;
         data_q     <= '0;
         carry_q    <= 1'b0;
      end else begin
         state <= state_nxt;
         if (acc0 || acc1) begin
            grant_q <= acc1;
            a_q     <= acc1 ? bus.req1_a : bus.req0_a;
            b_q     <= acc1 ? bus.req1_b : bus.req0_b;
            sel_q   <= acc1 ? bus.req1_sel : bus.req0_sel;
         end
         if (state == EXEC) begin
            data_q  <= bus.alu_out;
            carry_q <= bus.alu_carry;
         end
         if (rsp_done) begin
            last_grant <= grant_q;
         end
      end
   end

   assign bus.req0_ready = rdy0;
   assign bus.req1_ready = rdy1;
   assign bus.rsp0_valid = (state == RESP) && !grant_q;
   assign bus.rsp1_valid = (state == RESP) && grant_q;
   assign bus.rsp0_data  = data_q;
   assign bus.rsp1_data  = data_q;
   assign bus.rsp0_carry = carry_q;
   assign bus.rsp1_carry = carry_q;
   assign bus.alu_a      = a_q;
   assign bus.alu_b      = b_q;
   assign bus.alu_sel    = sel_q;
   assign bus.busy       = (state != IDLE);
   assign bus.grant_id   = grant_q;
endmodule
